// File: rtl/opc6_pkg.sv
// opc6_pkg: shared bus-controller state encoding and constants
package opc6_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MWAIT = 2'd1,
    IOREQ = 2'd2,
    ACK   = 2'd3
  } bus_state_e;
  localparam logic [15:0] IO_FF_DATA = 16'hFFFF;
endpackage

// File: rtl/opc6_sync.sv
// opc6_sync: DEPTH-deep reset-to-1 synchroniser for active-low async inputs
module opc6_sync #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [DEPTH-1:0][WIDTH-1:0] sync_q;
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) sync_q <= '1;
    else sync_q <= {sync_q[DEPTH-2:0], d_i};
  assign q_o = sync_q[DEPTH-1];
endmodule

// File: rtl/opc6_bus_ctl.sv
// opc6_bus_ctl: opc6 core bus controller with SRAM/IO strobes, clken stretching and irq sync
module opc6_bus_ctl
  import opc6_pkg::*;
#(
  parameter int MEM_WAIT   = 1,
  parameter int IO_TIMEOUT = 64,
  parameter int IRQ_SYNC   = 2
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_dout,
  input  logic        cpu_rnw,
  input  logic        cpu_vpa,
  input  logic        cpu_vda,
  input  logic        cpu_vio,
  output logic [15:0] cpu_din,
  output logic        cpu_clken,
  output logic [1:0]  cpu_int_b,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_ce_b,
  output logic        mem_oe_b,
  output logic        mem_we_b,
  output logic [7:0]  io_addr,
  output logic [15:0] io_wdata,
  input  logic [15:0] io_rdata,
  output logic        io_req,
  output logic        io_rnw,
  input  logic        io_ack,
  output logic        io_timeout,
  input  logic [1:0]  irq_b
);
  bus_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic        access, clken_c, strobe_c, io_req_c, timeout_c;
  assign access = cpu_vpa | cpu_vda | cpu_vio;
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    clken_c   = 1'b0;
    strobe_c  = 1'b0;
    io_req_c  = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      IDLE:
        if (!access) clken_c = 1'b1;
        else if (cpu_vio) begin
          cnt_d   = 8'(IO_TIMEOUT - 1);
          state_d = IOREQ;
        end else begin
          strobe_c = 1'b1;
          if (MEM_WAIT == 0) begin
            rdata_d = mem_rdata;
            state_d = ACK;
          end else begin
            cnt_d   = 8'(MEM_WAIT - 1);
            state_d = MWAIT;
          end
        end
      MWAIT: begin
        strobe_c = 1'b1;
        if (cnt_q == 8'd0) begin
          rdata_d = mem_rdata;
          state_d = ACK;
        end else cnt_d = cnt_q - 8'd1;
      end
      IOREQ: begin
        io_req_c = 1'b1;
        // ack beats expiry when both land in the same cycle
        if (io_ack) begin
          rdata_d = io_rdata;
          state_d = ACK;
        end else if (cnt_q == 8'd0) begin
          rdata_d   = IO_FF_DATA;
          timeout_c = 1'b1;
          state_d   = ACK;
        end else cnt_d = cnt_q - 8'd1;
      end
      ACK: begin
        clken_c = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  // strobes must drop the instant reset asserts, even mid-decode in IDLE
  assign mem_ce_b   = !(strobe_c && reset_b);
  assign mem_oe_b   = !(strobe_c && reset_b && cpu_rnw);
  assign mem_we_b   = !(strobe_c && reset_b && !cpu_rnw);
  assign cpu_clken  = clken_c | !reset_b;
  assign cpu_din    = rdata_q;
  assign mem_addr   = cpu_address;
  assign mem_wdata  = cpu_dout;
  assign io_addr    = cpu_address[7:0];
  assign io_wdata   = cpu_dout;
  assign io_rnw     = cpu_rnw;
  assign io_req     = io_req_c;
  assign io_timeout = timeout_c;
  opc6_sync #(.DEPTH(IRQ_SYNC), .WIDTH(2)) u_irq_sync (
    .clk     (clk),
    .reset_b (reset_b),
    .d_i     (irq_b),
    .q_o     (cpu_int_b)
  );
endmodule

// File: tb/tb_opc6_bus_ctl.sv
// tb_opc6_bus_ctl: randomized checks of two controller instances (MEM_WAIT 0 and 1) against a cycle-count model
module tb_opc6_bus_ctl;
  localparam int MW0  = 0;
  localparam int MW1  = 1;
  localparam int TMO  = 8;
  localparam int SYNC = 2;
  logic        clk, reset_b, rnw, vpa, vda, vio, io_ack;
  logic [15:0] addr, dout, mem_rdata, io_rdata;
  logic [1:0]  irq_b;
  logic [15:0] din[2], mem_addr[2], mem_wdata[2], io_wdata[2];
  logic        clken[2], ce_b[2], oe_b[2], we_b[2], io_req[2], io_rnw[2], io_to[2];
  logic [1:0]  int_b[2];
  logic [7:0]  io_addr[2];
  int checks = 0;
  int failures = 0;
  opc6_bus_ctl #(.MEM_WAIT(MW0), .IO_TIMEOUT(TMO), .IRQ_SYNC(SYNC)) u_dut0 (
    .clk(clk), .reset_b(reset_b), .cpu_address(addr), .cpu_dout(dout), .cpu_rnw(rnw),
    .cpu_vpa(vpa), .cpu_vda(vda), .cpu_vio(vio), .cpu_din(din[0]), .cpu_clken(clken[0]),
    .cpu_int_b(int_b[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata),
    .mem_ce_b(ce_b[0]), .mem_oe_b(oe_b[0]), .mem_we_b(we_b[0]), .io_addr(io_addr[0]),
    .io_wdata(io_wdata[0]), .io_rdata(io_rdata), .io_req(io_req[0]), .io_rnw(io_rnw[0]),
    .io_ack(io_ack), .io_timeout(io_to[0]), .irq_b(irq_b));
  opc6_bus_ctl #(.MEM_WAIT(MW1), .IO_TIMEOUT(TMO), .IRQ_SYNC(SYNC)) u_dut1 (
    .clk(clk), .reset_b(reset_b), .cpu_address(addr), .cpu_dout(dout), .cpu_rnw(rnw),
    .cpu_vpa(vpa), .cpu_vda(vda), .cpu_vio(vio), .cpu_din(din[1]), .cpu_clken(clken[1]),
    .cpu_int_b(int_b[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata),
    .mem_ce_b(ce_b[1]), .mem_oe_b(oe_b[1]), .mem_we_b(we_b[1]), .io_addr(io_addr[1]),
    .io_wdata(io_wdata[1]), .io_rdata(io_rdata), .io_req(io_req[1]), .io_rnw(io_rnw[1]),
    .io_ack(io_ack), .io_timeout(io_to[1]), .irq_b(irq_b));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask
  task automatic test_reset();
    reset_b = 1'b0;
    vpa = 1'b1;
    rnw = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      smp();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({clken[i], ce_b[i], oe_b[i], we_b[i], io_req[i], io_to[i]} !== 6'b111100) begin
          failures++;
          $display("FAIL reset_ctl dut%0d k=%0d got=%b exp=111100", i, k,
                   {clken[i], ce_b[i], oe_b[i], we_b[i], io_req[i], io_to[i]});
        end
        checks++;
        if ({int_b[i], din[i]} !== {2'b11, 16'h0000}) begin
          failures++;
          $display("FAIL reset_val dut%0d int_b=%b din=%h exp int_b=11 din=0000", i, int_b[i], din[i]);
        end
      end
    end
    vpa = 1'b0;
    cyc();
    reset_b = 1'b1;
    cyc();
  endtask
  task automatic mem_txn(input logic [15:0] a, input logic [15:0] wd, input logic [15:0] rd,
                         input logic r, input logic use_vda);
    int lat;
    logic last;
    cyc();
    addr = a; dout = wd; mem_rdata = rd; rnw = r;
    vpa = !use_vda; vda = use_vda; vio = 1'b0;
    for (int k = 0; k <= MW1 + 1; k++) begin
      if (k > 0) cyc();
      smp();
      for (int i = 0; i < 2; i++) begin
        lat = (i == 0) ? MW0 + 1 : MW1 + 1;
        if (k <= lat) begin
          last = (k == lat);
          checks++;
          if ({clken[i], ce_b[i], oe_b[i], we_b[i]} !== {last, last, last | !r, last | r}) begin
            failures++;
            $display("FAIL mem_strobe dut%0d k=%0d got=%b exp=%b", i, k,
                     {clken[i], ce_b[i], oe_b[i], we_b[i]}, {last, last, last | !r, last | r});
          end
          checks++;
          if ({mem_addr[i], mem_wdata[i]} !== {a, wd}) begin
            failures++;
            $display("FAIL mem_pass dut%0d got=%h/%h exp=%h/%h", i, mem_addr[i], mem_wdata[i], a, wd);
          end
          if (last && r) begin
            checks++;
            if (din[i] !== rd) begin
              failures++;
              $display("FAIL mem_rdata dut%0d got=%h exp=%h", i, din[i], rd);
            end
          end
        end
      end
    end
    cyc();
    vpa = 1'b0; vda = 1'b0;
    cyc();
    smp();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({clken[i], ce_b[i], oe_b[i], we_b[i]} !== 4'b1111) begin
        failures++;
        $display("FAIL mem_idle dut%0d got=%b exp=1111", i, {clken[i], ce_b[i], oe_b[i], we_b[i]});
      end
    end
  endtask
  task automatic test_mem();
    mem_txn(16'h0100, 16'h0000, 16'hA5C3, 1'b1, 1'b0);
    mem_txn(16'h0200, 16'h1234, 16'h5555, 1'b0, 1'b1);
    for (int n = 0; n < 8; n++)
      mem_txn(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
  endtask
  task automatic io_txn(input logic [7:0] port, input logic [15:0] wd, input logic [15:0] rd,
                        input logic r, input int ackd);
    int n;
    logic got_ack, exp_req, exp_to, exp_ck;
    got_ack = (ackd != 0);
    n = got_ack ? ackd : TMO;
    cyc();
    addr = {8'($urandom), port}; dout = wd; io_rdata = rd; rnw = r;
    vio = 1'b1; vpa = 1'($urandom); vda = 1'($urandom);
    for (int k = 0; k <= n + 1; k++) begin
      if (k > 0) begin
        cyc();
        io_ack = got_ack && (k == ackd);
      end
      smp();
      exp_req = (k >= 1) && (k <= n);
      exp_to = !got_ack && (k == n);
      exp_ck = (k == n + 1);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({clken[i], io_req[i], io_to[i]} !== {exp_ck, exp_req, exp_to}) begin
          failures++;
          $display("FAIL io_ctl dut%0d k=%0d ackd=%0d got=%b exp=%b", i, k, ackd,
                   {clken[i], io_req[i], io_to[i]}, {exp_ck, exp_req, exp_to});
        end
        checks++;
        if ({ce_b[i], oe_b[i], we_b[i]} !== 3'b111) begin
          failures++;
          $display("FAIL io_memquiet dut%0d k=%0d got=%b exp=111", i, k, {ce_b[i], oe_b[i], we_b[i]});
        end
        if (exp_req) begin
          checks++;
          if ({io_addr[i], io_wdata[i], io_rnw[i]} !== {port, wd, r}) begin
            failures++;
            $display("FAIL io_pass dut%0d got=%h/%h/%b exp=%h/%h/%b", i,
                     io_addr[i], io_wdata[i], io_rnw[i], port, wd, r);
          end
        end
        if (exp_ck && (r || !got_ack)) begin
          checks++;
          if (din[i] !== (got_ack ? rd : 16'hFFFF)) begin
            failures++;
            $display("FAIL io_rdata dut%0d got=%h exp=%h", i, din[i], got_ack ? rd : 16'hFFFF);
          end
        end
      end
    end
    cyc();
    vio = 1'b0; vpa = 1'b0; vda = 1'b0;
    io_ack = 1'b1;
    smp();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({clken[i], io_req[i], io_to[i]} !== 3'b100) begin
        failures++;
        $display("FAIL io_stray_ack dut%0d got=%b exp=100", i, {clken[i], io_req[i], io_to[i]});
      end
    end
    cyc();
    io_ack = 1'b0;
  endtask
  task automatic test_io();
    io_txn(8'h20, 16'h0000, 16'h0042, 1'b1, 5);
    io_txn(8'h31, 16'hBEEF, 16'h7777, 1'b0, 0);
    io_txn(8'h44, 16'h0000, 16'h1111, 1'b1, TMO);
    io_txn(8'h45, 16'h0000, 16'h2222, 1'b1, 0);
    for (int n = 0; n < 8; n++)
      io_txn(8'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, TMO)));
  endtask
  task automatic test_irq();
    logic [1:0] hist[$];
    cyc();
    vio = 1'b1; rnw = 1'b1;
    #2 irq_b = 2'b01;
    for (int k = 0; k <= SYNC; k++) begin
      if (k > 0) cyc();
      smp();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({int_b[i], clken[i]} !== {(k == SYNC) ? 2'b01 : 2'b11, 1'b0}) begin
          failures++;
          $display("FAIL irq_lat dut%0d k=%0d got int_b=%b clken=%b exp int_b=%b clken=0", i, k,
                   int_b[i], clken[i], (k == SYNC) ? 2'b01 : 2'b11);
        end
      end
    end
    for (int k = 0; k < SYNC; k++) hist.push_back(irq_b);
    for (int k = 0; k < 24; k++) begin
      cyc();
      irq_b = 2'($urandom);
      hist.push_back(irq_b);
      smp();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (int_b[i] !== hist[hist.size() - 1 - SYNC]) begin
          failures++;
          $display("FAIL irq_rand dut%0d k=%0d got=%b exp=%b", i, k, int_b[i], hist[hist.size() - 1 - SYNC]);
        end
      end
    end
    vio = 1'b0;
    irq_b = 2'b11;
    for (int k = 0; k < TMO + 4; k++) cyc();
  endtask
  task automatic test_reset_mid();
    cyc();
    addr = 16'($urandom); dout = 16'($urandom); rnw = 1'b0; vpa = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (k > 0) cyc();
      smp();
      checks++;
      if ({ce_b[1], we_b[1], clken[1]} !== 3'b000) begin
        failures++;
        $display("FAIL rstmid_pre k=%0d got=%b exp=000", k, {ce_b[1], we_b[1], clken[1]});
      end
    end
    #1 reset_b = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({clken[i], ce_b[i], oe_b[i], we_b[i], io_req[i], din[i]} !== {5'b11110, 16'h0000}) begin
        failures++;
        $display("FAIL rstmid_async dut%0d got=%b din=%h exp=11110 din=0000", i,
                 {clken[i], ce_b[i], oe_b[i], we_b[i], io_req[i]}, din[i]);
      end
    end
    cyc();
    vpa = 1'b0;
    cyc();
    reset_b = 1'b1;
    smp();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({clken[i], ce_b[i], we_b[i]} !== 3'b111) begin
        failures++;
        $display("FAIL rstmid_idle dut%0d got=%b exp=111", i, {clken[i], ce_b[i], we_b[i]});
      end
    end
    mem_txn(16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b0);
  endtask
  initial begin
    reset_b = 1'b0; addr = '0; dout = '0; rnw = 1'b1; vpa = 1'b0; vda = 1'b0; vio = 1'b0;
    mem_rdata = '0; io_rdata = '0; io_ack = 1'b0; irq_b = 2'b11;
    test_reset();
    test_mem();
    test_io();
    test_irq();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/opc6_bus_ctl.md
Name: opc6_bus_ctl

Overview:
- Bus controller between the opc6 CPU core and the system's memory and IO.
- Decodes the core's vpa/vda/vio cycle strobes and drives SRAM and IO-port strobes.
- Stretches each bus cycle through the core's clken input, so the core advances one FSM state only when data is valid.
- Presents read data on the core's din; synchronises the external interrupt lines into the core's int_b.

Parameters:
- MEM_WAIT, 1, extra wait cycles per memory access (0..15).
- IO_TIMEOUT, 64, maximum cycles to wait for io_ack before forcing completion (2..255).
- IRQ_SYNC, 2, synchroniser depth for irq_b (2 or 3).

Ports:
- clk  in  1  system clock
- reset_b  in  1  asynchronous active-low reset
- cpu_address  in  16  core address
- cpu_dout  in  16  core write data
- cpu_rnw  in  1  1=read, 0=write
- cpu_vpa  in  1  program/exec cycle valid
- cpu_vda  in  1  data memory cycle valid
- cpu_vio  in  1  IO cycle valid
- cpu_din  out  16  read data to core
- cpu_clken  out  1  core clock enable
- cpu_int_b  out  2  synchronised interrupts, active-low
- mem_addr  out  16  SRAM address
- mem_wdata  out  16  SRAM write data
- mem_rdata  in  16  SRAM read data
- mem_ce_b  out  1  chip enable, active-low
- mem_oe_b  out  1  output enable, active-low
- mem_we_b  out  1  write enable, active-low
- io_addr  out  8  IO port address (cpu_address[7:0])
- io_wdata  out  16  IO write data
- io_rdata  in  16  IO read data
- io_req  out  1  IO request, held until ack or timeout
- io_rnw  out  1  IO direction
- io_ack  in  1  IO completion, single-cycle
- io_timeout  out  1  one-cycle pulse when IO_TIMEOUT expires

Behaviour:
- Reset (async, reset_b=0):
  - state=IDLE, counters=0, rdata_q=0.
  - mem_ce_b=mem_oe_b=mem_we_b=1, io_req=0, io_timeout=0, cpu_int_b=2'b11, cpu_din=0.
  - cpu_clken is forced 1 combinationally while reset_b=0, so the core's internal reset synchroniser advances.
- Definitions: access = vpa|vda|vio; io_cyc = vio; mem_cyc = access & !vio.
- Core inputs are assumed stable while cpu_clken=0; the controller does not re-sample them mid-cycle.
- States: IDLE, MWAIT, IOREQ, ACK.
- IDLE:
  - No access: cpu_clken=1 (non-bus core states cost 1 cycle).
  - mem_cyc: cpu_clken=0.
    - MEM_WAIT=0: capture mem_rdata into rdata_q, go to ACK.
    - Otherwise: cnt=MEM_WAIT-1, go to MWAIT.
  - io_cyc: cpu_clken=0, cnt=IO_TIMEOUT-1, go to IOREQ.
- MWAIT:
  - cpu_clken=0.
  - cnt==0: capture mem_rdata, go to ACK.
  - Otherwise: cnt--.
- Memory strobes:
  - mem_ce_b=0 in the IDLE-with-mem_cyc cycle and throughout MWAIT.
  - mem_oe_b=!cpu_rnw and mem_we_b=cpu_rnw in those same cycles.
  - All strobes deasserted in ACK, giving one-cycle address/data hold after we_b rises.
  - mem_addr=cpu_address and mem_wdata=cpu_dout, both passed through.
- Memory latency: MEM_WAIT+2 clk cycles per memory cycle, cpu_clken high in the last one.
- IOREQ:
  - io_req=1, io_rnw=cpu_rnw, cpu_clken=0.
  - io_ack=1: capture io_rdata, go to ACK.
  - Else cnt==0: rdata_q=16'hFFFF, io_timeout=1 for that cycle, go to ACK.
  - Else cnt--.
  - io_ack and expiry in the same cycle: the ack wins and no timeout pulse is generated.
  - io_ack seen outside IOREQ is ignored.
- ACK:
  - cpu_clken=1 for exactly one cycle; cpu_din=rdata_q.
  - Next state is IDLE unconditionally; the next access is re-decoded there.
- cpu_din holds rdata_q at all times; for writes rdata_q holds the stale value, which the core ignores.
- Interrupts: irq_b[1:0] are external pins.
  - Add an input irq_b, 2 bits, async, active-low.
  - Each bit passes through an IRQ_SYNC-deep flop chain (reset to 1s) to form cpu_int_b.
  - cpu_int_b is not gated by clken.
- Reset asserted mid-access: all strobes drop asynchronously and the state returns to IDLE; no partial write completion is guaranteed.

Decomposition:
- Shared package opc6_pkg:
  - bus state encoding (IDLE=2'd0, MWAIT=2'd1, IOREQ=2'd2, ACK=2'd3)
  - IO_FF_DATA=16'hFFFF
- One sub-module, opc6_sync (IRQ_SYNC-deep reset-to-1 synchroniser, width parameter), instantiated once for irq_b.

Test Plan:
- Reset held 4 cycles with vpa=1 -> cpu_clken=1 all 4 cycles; strobes inactive; cpu_int_b=2'b11.
- Memory read, MEM_WAIT=1, addr 16'h0100, mem_rdata=16'hA5C3, vpa=1 rnw=1:
  - mem_ce_b=mem_oe_b=0 for 2 cycles;
  - cpu_clken=1 only on cycle 3 with cpu_din=16'hA5C3.
- Memory write, MEM_WAIT=0, dout=16'h1234, vda=1 rnw=0:
  - mem_we_b=0 for 1 cycle, then cpu_clken=1 with we_b=1;
  - mem_wdata=16'h1234 across both cycles.
- IO read, port 8'h20, io_ack after 5 cycles with io_rdata=16'h0042:
  - io_req high 5 cycles, drops after ack;
  - next cycle cpu_clken=1, cpu_din=16'h0042.
- IO write, IO_TIMEOUT=8, no ack:
  - io_req high 8 cycles, io_timeout pulses on the 8th;
  - then cpu_clken=1, cpu_din=16'hFFFF.
  - Separately, ack in the expiry cycle -> no timeout pulse.
- irq_b[1] driven low asynchronously -> cpu_int_b[1]=0 within IRQ_SYNC+1 cycles, independent of cpu_clken.
  - reset_b pulsed low during MWAIT -> strobes high immediately; state IDLE.
